gcd_sub_engine: RTL and testbench
=================================

# gcd_sub_engine

Parametrised, multi-cycle greatest-common-divisor engine using Euclid's subtraction method. It is the sequential successor of the team's fixed 4-bit two's-complement subtractor: the same add-inverted-plus-one datapath, widened to `WIDTH` bits, with its carry-out reused as an `a >= b` comparator. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  engine can accept; equals (state == IDLE).
- `a`  in  WIDTH  first operand, unsigned.
- `b`  in  WIDTH  second operand, unsigned.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  consumer accepts result.
- `gcd`  out  WIDTH  result, registered.
- `steps`  out  WIDTH  number of subtractions performed, registered.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready` = 1. On `in_valid && in_ready`, latch `a` into `ra` and `b` into `rb`, clear the step count, then branch:
  - If `a == 0` or `b == 0`: go to DONE, with `gcd <= a | b` and `steps <= 0`. gcd(0,0) = 0.
  - Otherwise: go to CALC.
- CALC, one action per clock edge:
  - If `ra == rb`: `gcd <= ra`, go to DONE.
  - Else if `ra > rb`: `ra <= ra - rb`, increment the count.
  - Else: `rb <= rb - ra`, increment the count.
- Subtraction is `x + ~y + 1` on WIDTH bits. Carry-out = 1 means `x >= y`. Equality is `diff == 0` with carry = 1.
- Operands stay nonzero in CALC, so no wrap-around can occur. The count never exceeds 2^WIDTH − 2, so it never saturates.
- DONE: `out_valid` = 1. `gcd` and `steps` are held stable while `out_ready` = 0. On `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. There is no queuing.

## Timing
- Reset (asynchronous assert, any state): state = IDLE. `out_valid` = 0, `gcd` = 0, `steps` = 0, `ra` = `rb` = 0. `in_ready` = 1 while in reset and after it.
- Deassertion of `rst_n` takes effect on the next rising edge. Synchronising the deassertion is the integrator's responsibility.
- Latency, accept edge E0 to `out_valid` visible:
  - Zero operand: after E0.
  - Otherwise: after E(steps + 1).
- `in_ready` rises the cycle after the result handshake, giving one idle cycle minimum between jobs. No combinational path from `in_valid` to `out_valid`.
- A result handshake edge and a new `in_valid` in the same cycle: the new pair is not accepted, because `in_ready` = 0 in DONE.
- Reset during CALC or DONE: the job is discarded, and no `out_valid` follows for it.

## Structure
- Shared package `gcd_pkg`:
  - state encoding enum `gcd_state_t` (IDLE=0, CALC=1, DONE=2);
  - `GCD_WIDTH_MAX` = 32.
- One sub-module `sub_nbit #(WIDTH)`:
  - combinational `x`, `y` → `diff`, `cout` (no borrow);
  - `~y` with carry-in 1.
- Two `sub_nbit` instances (`ra − rb` and `rb − ra`) feed the CALC muxes. The engine holds the FSM, operand registers, step counter and output registers.

## Test plan
- WIDTH=4, (12, 8), `out_ready` = 1 → `gcd` = 4, `steps` = 2, `out_valid` after E3, single-cycle pulse.
- WIDTH=4, (0, 9) then (0, 0) → `gcd` = 9 then 0, `steps` = 0, `out_valid` after E0 each time.
- WIDTH=4, (15, 1) → `gcd` = 1, `steps` = 14, `out_valid` after E15. Worst case, no wrap.
- WIDTH=8, (255, 170) with `out_ready` held low 5 cycles:
  - `gcd` = 85, `steps` = 2;
  - outputs stable for all 5 cycles;
  - `in_valid` pulses during DONE are not accepted.
- WIDTH=4, (14, 6): assert `rst_n` = 0 after E2, then release and send (9, 6):
  - immediately on reset, `out_valid` = 0, `gcd` = 0, `in_ready` = 1;
  - no `out_valid` appears for the aborted job;
  - the next job gives `gcd` = 3, `steps` = 2.
- Randomised back-to-back, WIDTH=6, 1000 pairs → every result matches a reference Euclid model, and `steps` matches the model's subtraction count.

Source files
------------

// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_pkg
// Brief    : Shared state encoding and limits for the GCD subtraction engine.
// Revision : 1.0
// ============================================================================
package gcd_pkg;

    localparam int GCD_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage : gcd_pkg
`default_nettype wire

// File: rtl/sub_nbit.sv
`default_nettype none
// ============================================================================
// Module   : sub_nbit
// Brief    : WIDTH-bit subtractor x + ~y + 1; carry-out set means x >= y.
// Revision : 1.0
// ============================================================================
module sub_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] diff,
    output logic             cout
);

    logic [WIDTH:0] w_sum;

    // One extra bit captures the carry out of the inverted-add.
    assign w_sum = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    assign diff  = w_sum[WIDTH-1:0];
    assign cout  = w_sum[WIDTH];

endmodule : sub_nbit
`default_nettype wire

// File: rtl/gcd_sub_engine.sv
`default_nettype none
// ============================================================================
// Module   : gcd_sub_engine
// Brief    : Multi-cycle Euclid-by-subtraction GCD with valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module gcd_sub_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic [WIDTH-1:0] steps
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        if (WIDTH < 2 || WIDTH > GCD_WIDTH_MAX) begin : g_width_check
            $error("gcd_sub_engine: WIDTH out of range 2..32");
        end
    endgenerate

    gcd_state_t       r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_gcd;
    logic [WIDTH-1:0] r_steps;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_diff_ab;
    logic [WIDTH-1:0] w_diff_ba;
    logic             w_cout_ab;
    logic             w_cout_ba;
    logic             w_eq;
    logic             w_a_gt_b;
    logic             w_b_gt_a;
    logic             w_zero_op;

    sub_nbit #(.WIDTH(WIDTH)) u_sub_ab (
        .x    (r_ra),
        .y    (r_rb),
        .diff (w_diff_ab),
        .cout (w_cout_ab)
    );

    sub_nbit #(.WIDTH(WIDTH)) u_sub_ba (
        .x    (r_rb),
        .y    (r_ra),
        .diff (w_diff_ba),
        .cout (w_cout_ba)
    );

    // Carry-out doubles as the >= comparator; a zero difference splits >= into == and >.
    assign w_eq      = w_cout_ab & ~(|w_diff_ab);
    assign w_a_gt_b  = w_cout_ab &  (|w_diff_ab);
    assign w_b_gt_a  = w_cout_ba &  (|w_diff_ba);
    assign w_zero_op = (a == '0) || (b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ra        <= '0;
            r_rb        <= '0;
            r_cnt       <= '0;
            r_gcd       <= '0;
            r_steps     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ra  <= a;
                        r_rb  <= b;
                        r_cnt <= '0;
                        if (w_zero_op) begin
                            r_gcd       <= a | b;
                            r_steps     <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (w_eq) begin
                        r_gcd       <= r_ra;
                        r_steps     <= r_cnt;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_a_gt_b) begin
                        r_ra  <= w_diff_ab;
                        r_cnt <= r_cnt + c_one;
                    end else if (w_b_gt_a) begin
                        r_rb  <= w_diff_ba;
                        r_cnt <= r_cnt + c_one;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign gcd       = r_gcd;
    assign steps     = r_steps;

endmodule : gcd_sub_engine
`default_nettype wire

// File: tb/tb_gcd_sub_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_sub_engine
// Brief    : Directed and model-checked bench for gcd_sub_engine at WIDTH 4/8/6.
// Revision : 1.0
// ============================================================================
module tb_gcd_sub_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid4 = 1'b0, out_ready4 = 1'b1, in_ready4, out_valid4;
    logic [3:0] a4 = '0, b4 = '0, gcd4, steps4;
    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, in_ready8, out_valid8;
    logic [7:0] a8 = '0, b8 = '0, gcd8, steps8;
    logic       in_valid6 = 1'b0, out_ready6 = 1'b1, in_ready6, out_valid6;
    logic [5:0] a6 = '0, b6 = '0, gcd6, steps6;

    int total = 0;
    int bad   = 0;

    gcd_sub_engine #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .gcd(gcd4), .steps(steps4)
    );
    gcd_sub_engine #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .gcd(gcd8), .steps(steps8)
    );
    gcd_sub_engine #(.WIDTH(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .a(a6), .b(b6), .out_valid(out_valid6), .out_ready(out_ready6),
        .gcd(gcd6), .steps(steps6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_gcd(input int x, input int y, output int g, output int s);
        s = 0;
        if (x == 0 || y == 0) begin
            g = x | y;
        end else begin
            while (x != y) begin
                if (x > y) x = x - y;
                else       y = y - x;
                s++;
            end
            g = x;
        end
    endfunction

    // Single job on the WIDTH=4 engine with out_ready held high.
    task automatic job4(input string tag, input int ia, input int ib,
                        input int eg, input int es, input int elat);
        int n;
        int lat;
        n = 0;
        while (!in_ready4 && n < 100) begin tick(); n++; end
        check({tag, "_rdy"}, in_ready4, 1);
        a4 = ia[3:0]; b4 = ib[3:0]; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 100) begin tick(); lat++; end
        check({tag, "_lat"},   lat,    elat);
        check({tag, "_gcd"},   gcd4,   eg);
        check({tag, "_steps"}, steps4, es);
        tick();
        check({tag, "_pulse"}, out_valid4, 0);
        check({tag, "_rdy2"},  in_ready4,  1);
    endtask

    initial begin
        int seen;
        int lat;
        int eg;
        int es;
        int xa;
        int xb;
        int n;

        #2;
        check("rst_ov",  out_valid4, 0);
        check("rst_gcd", gcd4,       0);
        check("rst_st",  steps4,     0);
        check("rst_rdy", in_ready4,  1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        job4("g12_8",  12, 8, 4, 2, 3);
        job4("g0_9",   0,  9, 9, 0, 0);
        job4("g0_0",   0,  0, 0, 0, 0);
        job4("g15_1",  15, 1, 1, 14, 15);

        // Backpressured WIDTH=8 job with in_valid pulses during DONE.
        a8 = 8'd255; b8 = 8'd170; in_valid8 = 1'b1; out_ready8 = 1'b0;
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin tick(); lat++; end
        check("w8_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            a8 = 8'd7; b8 = 8'd3; in_valid8 = (i % 2 == 0);
            tick();
            check("w8_hold_ov",  out_valid8, 1);
            check("w8_hold_gcd", gcd8,       85);
            check("w8_hold_st",  steps8,     2);
            check("w8_hold_rdy", in_ready8,  0);
        end
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        check("w8_hs_ov",  out_valid8, 0);
        check("w8_hs_rdy", in_ready8,  1);
        tick();
        check("w8_idle_gcd", gcd8,      85);
        check("w8_idle_rdy", in_ready8, 1);
        check("w8_idle_ov",  out_valid8, 0);

        // Reset in the middle of a CALC job.
        a4 = 4'd14; b4 = 4'd6; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort_ov",  out_valid4, 0);
        check("abort_gcd", gcd4,       0);
        check("abort_st",  steps4,     0);
        check("abort_rdy", in_ready4,  1);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid4) seen = 1;
        end
        check("abort_nov", seen, 0);
        job4("g9_6", 9, 6, 3, 2, 3);

        // Back-to-back random traffic on the WIDTH=6 engine.
        for (int k = 0; k < 1000; k++) begin
            xa = $urandom_range(0, 63);
            xb = $urandom_range(0, 63);
            ref_gcd(xa, xb, eg, es);
            n = 0;
            while (!in_ready6 && n < 200) begin tick(); n++; end
            if (!in_ready6) check("rnd_rdy", in_ready6, 1);
            a6 = xa[5:0]; b6 = xb[5:0]; in_valid6 = 1'b1;
            tick();
            in_valid6 = 1'b0;
            lat = 0;
            while (!out_valid6 && lat < 200) begin tick(); lat++; end
            check("rnd_gcd",   gcd6,   eg);
            check("rnd_steps", steps6, es);
            check("rnd_lat",   lat,    (xa == 0 || xb == 0) ? 0 : es + 1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gcd_sub_engine
`default_nettype wire
